// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit.
// Multiply is radix-2 shift-add and divide is restoring division. Both work on
// operand magnitudes, and the sign is fixed up in FIN. funct3, the operands and
// rd are latched when start is accepted. result/rd_out only change on a
// completed op.
// Build option MDU_DIV_EN: when defined, the divider is present. When it is
// not defined, funct3 4..7 gives a one-cycle illegal pulse instead of an op.
// Handshake: start is accepted only in IDLE (busy=0). done is a one-cycle pulse,
// and result/rd_out carry the new value in that cycle. flush aborts an op in
// CALC or FIN and suppresses its done.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            illegal,
  output logic [1:0]      dbg_state
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIN = 2'd2} state_t;
  state_t r_state, w_next;

  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_b;       // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] r_acc;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic              r_neg_q;   // product / quotient needs negation
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_lat, r_rd_out;
  logic              r_illegal;

  logic              w_accept, w_illegal_req, w_fin_ok;
  logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_final;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_step, w_prod_fix;

`ifdef MDU_DIV_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic              r_neg_r;   // remainder needs negation (sign of A)
  logic              r_special; // result preloaded, iterations bypassed
  logic              w_div0, w_ovf, w_special;
  logic [XLEN-1:0]   w_special_val;
  logic [XLEN:0]     w_div_shift, w_div_diff;
  assign w_accept      = (r_state == S_IDLE) && start;
  assign w_illegal_req = 1'b0;
`else
  assign w_accept      = (r_state == S_IDLE) && start && !funct3[2];
  assign w_illegal_req = (r_state == S_IDLE) && start && funct3[2];
`endif

  // Operand signedness and magnitudes for the op being launched
  always_comb begin
    w_a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    w_b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    w_a_neg    = w_a_signed && rs1_val[XLEN-1];
    w_b_neg    = w_b_signed && rs2_val[XLEN-1];
    w_mag_a    = w_a_neg ? -rs1_val : rs1_val;
    w_mag_b    = w_b_neg ? -rs2_val : rs2_val;
`ifdef MDU_DIV_EN
    w_div0     = (rs2_val == '0);
    w_ovf      = ((funct3 == 3'd4) || (funct3 == 3'd6)) && (rs1_val == MIN_NEG) && (rs2_val == '1);
    w_special  = funct3[2] && (w_div0 || w_ovf);
    if (w_div0) w_special_val = funct3[1] ? rs1_val : '1;
    else        w_special_val = funct3[1] ? '0 : rs1_val;
`endif
  end

  // One iteration of the shift-add multiplier or the restoring divider
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_b : {XLEN{1'b0}})};
    w_step    = {w_mul_sum, r_acc[XLEN-1:1]};
`ifdef MDU_DIV_EN
    w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    w_div_diff  = w_div_shift - {1'b0, r_b};
    if (r_op[2]) begin
      if (w_div_diff[XLEN]) w_step = {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      else                  w_step = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end
    if (r_special) w_step = r_acc;
`endif
  end

  // Sign fix-up and result selection applied in FIN
  always_comb begin
    w_prod_fix = r_neg_q ? -r_acc : r_acc;
    w_final    = (r_op == 3'd0) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
    if (r_special) begin
      w_final = r_acc[XLEN-1:0];
    end else if (r_op[2]) begin
      if (r_op[1]) w_final = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
      else         w_final = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // FSM next state: flush returns to IDLE from CALC/FIN
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CALC;
      S_CALC:  if (flush) w_next = S_IDLE;
               else if (r_cnt == LAST) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch on accept, one iteration per CALC cycle.
  // Special divide cases preload the answer and park the counter at its last
  // value, so they pass through a single idle CALC cycle before FIN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_neg_q  <= 1'b0;
      r_rd_lat <= '0;
`ifdef MDU_DIV_EN
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
`endif
    end else if (w_accept) begin
      r_op     <= funct3;
      r_rd_lat <= rd_in;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_cnt    <= '0;
      r_b      <= funct3[2] ? w_mag_b : w_mag_a;
      r_acc    <= {{XLEN{1'b0}}, (funct3[2] ? w_mag_a : w_mag_b)};
`ifdef MDU_DIV_EN
      r_neg_r   <= w_a_neg;
      r_special <= w_special;
      if (w_special) begin
        r_cnt <= LAST;
        r_acc <= {{XLEN{1'b0}}, w_special_val};
      end
`endif
    end else if ((r_state == S_CALC) && !flush) begin
      r_cnt <= r_cnt + CW'(1);
      r_acc <= w_step;
    end
  end

  // Result/rd hold registers and the illegal pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result  <= '0;
      r_rd_out  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_illegal_req;
      if (w_fin_ok) begin
        r_result <= w_final;
        r_rd_out <= r_rd_lat;
      end
    end
  end

  assign w_fin_ok  = (r_state == S_FIN) && !flush;
  assign busy      = (r_state != S_IDLE);
  assign done      = w_fin_ok;
  assign result    = w_fin_ok ? w_final : r_result;
  assign rd_out    = w_fin_ok ? r_rd_lat : r_rd_out;
  assign illegal   = r_illegal;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed plus randomized bench for mul_div_unit against an arithmetic model.
// Timing: lat counts rising edges after the edge that accepts start. A normal op
// shows done after lat=XLEN (done at T+XLEN+1). A special divide shows done
// after lat=1 (done at T+2).
module tb_mul_div_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_val = '0, rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, illegal;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [4:0]      exp_rd_q[$];
  logic [XLEN-1:0] last_result = '0;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // behavioural model straight from the RV32M definitions
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = longint'(ua / ub); return q[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = longint'(ua % ub); return q[31:0];
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == MIN_NEG && b == 32'hFFFF_FFFF))) return 1;
    return XLEN;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return MIN_NEG;
      4: return $urandom_range(0, 300);
      default: return $urandom;
    endcase
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // launch one op and score it; poke asserts start mid-op (must be ignored)
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit poke);
    int lat;
    logic [31:0] e;
    logic [4:0] erd;
    exp_q.push_back(ref_model(f3, a, b));
    exp_rd_q.push_back(rd);
    @(negedge clk);
    funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rs1_val = $urandom; rs2_val = $urandom; rd_in = 5'($urandom_range(0, 31));
    check("busy_after_start", busy, 1);
    lat = 0;
    while (!done && lat < XLEN + 8) begin
      @(posedge clk); #1;
      lat++;
      if (poke) start = (lat == 5);
    end
    start = 1'b0;
    check($sformatf("done_latency_f%0d", f3), lat, exp_latency(f3, a, b));
    check("busy_at_done", busy, 1);
    e   = exp_q.pop_front();
    erd = exp_rd_q.pop_front();
    check($sformatf("result_f%0d_%h_%h", f3, a, b), result, e);
    check("rd_out", rd_out, erd);
    last_result = e;
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_drop", busy, 0);
    check("result_held", result, e);
  endtask

  task automatic watch_no_done(input int cycles, input string tag);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    apply_reset();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_illegal", illegal, 0);
    check("reset_result", result, 0);
    check("reset_rd_out", rd_out, 0);

    // directed multiply vectors
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 1'b0);
    check("mul_const", result, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    check("mulhu_const", result, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
    check("mulh_const", result, 32'h0000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);

    // random multiplies, one with a stray start mid-op
    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(0, 3));
      run_op(f3, pick(), pick(), 5'($urandom_range(0, 31)), i == 0);
    end

`ifdef MDU_DIV_EN
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
    check("div_const", result, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b0);
    check("rem_const", result, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 5'd10, 1'b0);
    check("divu_const", result, 32'd14);
    run_op(3'd4, 32'd5, 32'd0, 5'd11, 1'b0);
    check("div0_const", result, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd5, 32'd0, 5'd12, 1'b0);
    check("remu0_const", result, 32'd5);
    run_op(3'd4, MIN_NEG, 32'hFFFF_FFFF, 5'd13, 1'b0);
    check("div_ovf_const", result, MIN_NEG);
    run_op(3'd6, MIN_NEG, 32'hFFFF_FFFF, 5'd14, 1'b0);
    check("rem_ovf_const", result, 32'd0);
    for (int i = 0; i < 20; i++) begin
      f3 = 3'($urandom_range(4, 7));
      run_op(f3, pick(), pick(), 5'($urandom_range(0, 31)), i == 0);
    end
`else
    // divide ops are rejected with a single illegal pulse
    for (int k = 4; k < 8; k++) begin
      @(negedge clk);
      funct3 = 3'(k); rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("illegal_pulse_f%0d", k), illegal, 1);
      check("illegal_busy", busy, 0);
      @(posedge clk); #1;
      check("illegal_one_cycle", illegal, 0);
      watch_no_done(XLEN + 4, "illegal_no_done");
      check("illegal_result_kept", result, last_result);
    end
`endif

    // flush mid-multiply: sampled at edge T+10, busy gone at T+11
    @(negedge clk);
    funct3 = 3'd0; rs1_val = $urandom; rs2_val = $urandom; rd_in = 5'd21; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    check("flush_result_kept", result, last_result);
    watch_no_done(XLEN + 4, "flush_no_done");
    a = pick(); b = pick();
    run_op(3'd3, a, b, 5'd22, 1'b0);

    // asynchronous reset in the middle of an op
    @(negedge clk);
`ifdef MDU_DIV_EN
    funct3 = 3'd4;
`else
    funct3 = 3'd0;
`endif
    rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_rd_out", rd_out, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    watch_no_done(XLEN + 4, "arst_no_done");
    run_op(3'd0, pick(), pick(), 5'd30, 1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
